// File: rtl/key_onehot_latch_if.sv
// Key-latch bus: raw key levels and clear in, held one-hot code and load pulse out.
interface key_onehot_latch_if;
  logic [9:0] key_in;
  logic       clr;
  logic [9:0] out;
  logic       new_key;

  // Board side / stimulus: drives the keys and the clear, observes the code.
  modport master (
    output key_in,
    output clr,
    input  out,
    input  new_key
  );

  // The latch block itself.
  modport slave (
    input  key_in,
    input  clr,
    output out,
    output new_key
  );
endinterface

// File: rtl/key_onehot_latch.sv
// Debounces ten keys, detects new presses and holds a one-hot code of the most
// recently pressed key. The output is always zero or a single set bit, so it can
// feed the 7-segment decoder's one-hot input directly.
module key_onehot_latch #(
  parameter int TICK_DIV       = 50000, // clocks per debounce sample tick, >= 2
  parameter int DB_SAMPLES     = 8,     // equal samples needed to flip a key, >= 2
  parameter int KEY_ACTIVE_LOW = 1      // 1: a low key_in bit means pressed
) (
  input  logic              clk,
  input  logic              rst,
  key_onehot_latch_if.slave bus
);

  localparam int                N_KEYS   = 10;
  localparam int                CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic              POL      = (KEY_ACTIVE_LOW != 0);

  logic [N_KEYS-1:0]                 pressed_raw;
  logic [N_KEYS-1:0]                 sync1;
  logic [N_KEYS-1:0]                 sync2;
  logic [CNT_W-1:0]                  cnt;
  logic                              tick;
  logic [N_KEYS-1:0][DB_SAMPLES-1:0] hist;
  logic [N_KEYS-1:0][DB_SAMPLES-1:0] hist_next;
  logic [N_KEYS-1:0]                 db;
  logic [N_KEYS-1:0]                 db_prev;
  logic [N_KEYS-1:0]                 ev;
  logic [N_KEYS-1:0]                 ev_low;
  logic [N_KEYS-1:0]                 out_q;
  logic                              new_key_q;

  // Normalize polarity so a 1 always means "pressed".
  assign pressed_raw = bus.key_in ^ {N_KEYS{POL}};

  // Two-flop synchronizer per key; the raw pins are asynchronous to clk.
  // NOTE: every register here uses non-blocking assignments so all flops
  // sample the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pressed_raw;
      sync2 <= sync1;
    end
  end

  // Free-running sample-tick divider; clr deliberately has no effect on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

  // History after shifting in the current synced sample.
  always_comb begin
    hist_next = hist;
    for (int i = 0; i < N_KEYS; i++) begin
      hist_next[i] = {hist[i][DB_SAMPLES-2:0], sync2[i]};
    end
  end

  // On each tick shift in a sample; flip the debounced state only when the
  // whole history agrees, otherwise hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      db   <= '0;
    end else if (tick) begin
      hist <= hist_next;
      for (int i = 0; i < N_KEYS; i++) begin
        if (&hist_next[i]) begin
          db[i] <= 1'b1;
        end else if (~|hist_next[i]) begin
          db[i] <= 1'b0;
        end
      end
    end
  end

  // Delayed copy of the debounced state for rising-edge (press) detection.
  // NOTE: db_prev resets to "released" like db, so a key held through reset
  // produces a fresh press event once its debounce completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev <= '0;
    end else begin
      db_prev <= db;
    end
  end

  assign ev = db & ~db_prev;

  // Isolate the lowest set event bit; higher simultaneous presses are dropped.
  assign ev_low = ev & (~ev + N_KEYS'(1));

  // Held code: clear wins over a press in the same cycle; otherwise the newest
  // press reloads the code (even if it is the key already held).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      new_key_q <= 1'b0;
    end else if (bus.clr) begin
      out_q     <= '0;
      new_key_q <= 1'b0;
    end else if (|ev) begin
      out_q     <= ev_low;
      new_key_q <= 1'b1;
    end else begin
      new_key_q <= 1'b0;
    end
  end

  assign bus.out     = out_q;
  assign bus.new_key = new_key_q;

endmodule

// File: tb/tb_key_onehot_latch.sv
// Bench for key_onehot_latch: expected codes are queued when a press is driven
// and compared against out whenever new_key pulses.
module tb_key_onehot_latch;

  logic clk = 1'b0;
  logic rst;

  key_onehot_latch_if bus ();

  key_onehot_latch #(
    .TICK_DIV       (4),
    .DB_SAMPLES     (3),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp      = 0;
  int         n_bad      = 0;
  int         nk_count   = 0;
  int         tick_count = 0;
  bit         mon_en     = 1'b0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: one-hot invariant every cycle, scoreboard pop on every load pulse.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("onehot0", 32'($onehot0(bus.out)), 32'd1);
      if (dut.tick) tick_count++;
      if (bus.new_key) begin
        nk_count++;
        if (exp_q.size() == 0) begin
          check("spurious_new_key", 32'd1, 32'd0);
        end else begin
          check("out_on_new_key", 32'(bus.out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  int nk0;
  int t0;

  initial begin
    rst        = 1'b1;
    bus.key_in = 10'h3FF;
    bus.clr    = 1'b0;
    #12;
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_new_key", 32'(bus.new_key), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // 1: idle after reset, all keys released
    nk0 = nk_count;
    t0  = tick_count;
    cycles(200);
    check("t1_no_new_key", 32'(nk_count - nk0), 32'd0);
    check("t1_out_zero", 32'(bus.out), 32'd0);
    check("t1_tick_count", 32'(tick_count - t0), 32'd50);

    // 2: single press of key 3, then release
    nk0 = nk_count;
    exp_q.push_back(10'd8);
    bus.key_in[3] = 1'b0;
    cycles(40);
    check("t2_one_pulse", 32'(nk_count - nk0), 32'd1);
    check("t2_out", 32'(bus.out), 32'd8);
    bus.key_in[3] = 1'b1;
    cycles(40);
    check("t2_hold_after_release", 32'(bus.out), 32'd8);

    // 3: short glitch on key 5
    nk0 = nk_count;
    bus.key_in[5] = 1'b0;
    cycles(6);
    bus.key_in[5] = 1'b1;
    cycles(40);
    check("t3_no_pulse", 32'(nk_count - nk0), 32'd0);
    check("t3_out", 32'(bus.out), 32'd8);

    // 4: simultaneous keys 7 and 2, lowest wins; then key 7 alone
    nk0 = nk_count;
    exp_q.push_back(10'd4);
    bus.key_in[7] = 1'b0;
    bus.key_in[2] = 1'b0;
    cycles(40);
    check("t4_one_pulse", 32'(nk_count - nk0), 32'd1);
    check("t4_out_low_wins", 32'(bus.out), 32'd4);
    bus.key_in[7] = 1'b1;
    bus.key_in[2] = 1'b1;
    cycles(40);
    check("t4_release_holds", 32'(bus.out), 32'd4);
    exp_q.push_back(10'd128);
    bus.key_in[7] = 1'b0;
    cycles(40);
    check("t4_out_key7", 32'(bus.out), 32'd128);
    bus.key_in[7] = 1'b1;
    cycles(40);

    // 5: key 9 event while clr is high is discarded; later clr alone clears
    nk0 = nk_count;
    bus.clr = 1'b1;
    bus.key_in[9] = 1'b0;
    cycles(40);
    bus.clr = 1'b0;
    cycles(2);
    check("t5_clr_out", 32'(bus.out), 32'd0);
    check("t5_clr_no_pulse", 32'(nk_count - nk0), 32'd0);
    bus.key_in[9] = 1'b1;
    cycles(40);
    exp_q.push_back(10'd512);
    bus.key_in[9] = 1'b0;
    cycles(40);
    check("t5_out_key9", 32'(bus.out), 32'd512);
    bus.key_in[9] = 1'b1;
    cycles(40);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("t5_clr_alone_out", 32'(bus.out), 32'd0);
    check("t5_clr_alone_nk", 32'(bus.new_key), 32'd0);

    // 6: press and re-press key 0, then reset mid-debounce of key 4
    nk0 = nk_count;
    exp_q.push_back(10'd1);
    bus.key_in[0] = 1'b0;
    cycles(40);
    check("t6_out_key0", 32'(bus.out), 32'd1);
    bus.key_in[0] = 1'b1;
    cycles(40);
    exp_q.push_back(10'd1);
    bus.key_in[0] = 1'b0;
    cycles(40);
    check("t6_repress_pulses", 32'(nk_count - nk0), 32'd2);
    check("t6_repress_out", 32'(bus.out), 32'd1);
    bus.key_in[0] = 1'b1;
    cycles(40);

    exp_q.push_back(10'd16);
    bus.key_in[4] = 1'b0;
    cycles(6);
    #2 rst = 1'b1;
    #1;
    check("t6_async_rst_out", 32'(bus.out), 32'd0);
    check("t6_async_rst_nk", 32'(bus.new_key), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nk0 = nk_count;
    cycles(8);
    check("t6_no_early_event", 32'(nk_count - nk0), 32'd0);
    check("t6_out_still_zero", 32'(bus.out), 32'd0);
    cycles(40);
    check("t6_held_through_rst", 32'(bus.out), 32'd16);
    check("t6_one_pulse_after_rst", 32'(nk_count - nk0), 32'd1);
    bus.key_in[4] = 1'b1;
    cycles(20);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
